leaf_stream_adapter: RTL
========================

Name: leaf_stream_adapter

Overview:
- Per-input-port adapter directly downstream of the leaf interface's user side.
- Consumes the vld/ack word stream for one input port and buffers it in a small first-word-fall-through FIFO.
- Re-presents the words as an AXI-Stream master to the HLS operator, generating tlast from a run-time frame length.
- Restarts on each ap_start rising edge and pulses done when the whole frame has been delivered.

Parameters:
- PAYLOAD_BITS, 32, width of one data word; equals the leaf interface payload width.
- FIFO_ADDR_BITS, 4, FIFO depth = 2^FIFO_ADDR_BITS words.
- LEN_BITS, 16, width of the frame length and word counters.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- ap_start  input  1  kernel start level; a rising edge starts a new frame.
- frame_len  input  LEN_BITS  words per frame; sampled on the start pulse.
- din_leaf_interface2user  input  PAYLOAD_BITS  word from the leaf interface.
- vld_interface2user  input  1  din is valid.
- ack_user2interface  output  1  adapter accepts din this cycle.
- m_tdata  output  PAYLOAD_BITS  stream data to the operator.
- m_tvalid  output  1  stream valid.
- m_tready  input  1  operator ready.
- m_tlast  output  1  final word of the frame.
- done  output  1  one-cycle pulse after the last word is transferred.
- busy  output  1  high in the STREAM state.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - State goes to IDLE; FIFO count, pointers, in_cnt and out_cnt go to 0; len_q goes to 0; ap_start_q goes to 0.
  - Outputs: ack=0, m_tvalid=0, m_tlast=0, done=0, busy=0, m_tdata=0.
  - A reset mid-frame discards all buffered words.
- Start detection:
  - ap_start_q is a registered copy of ap_start.
  - start = ap_start & ~ap_start_q, combinational, so it is high in the first cycle ap_start is sampled high.
- IDLE:
  - ack=0, m_tvalid=0.
  - On start with frame_len!=0: latch len_q=frame_len, clear FIFO and counters, go to STREAM.
  - On start with frame_len==0: go to DONE directly; no words are accepted.
- STREAM:
  - ack = (fifo_count < 2^FIFO_ADDR_BITS) && (in_cnt < len_q). Derived from registers only; no combinational path from m_tready.
  - Push when vld & ack; in_cnt increments on each push.
  - m_tvalid = (fifo_count != 0); m_tdata = FIFO head.
  - A word pushed at edge t is visible on m_tdata/m_tvalid after edge t, i.e. 1-cycle latency.
  - Pop when m_tvalid & m_tready; out_cnt increments on each pop.
  - m_tlast = m_tvalid && (out_cnt == len_q-1).
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo 2^FIFO_ADDR_BITS; count is FIFO_ADDR_BITS+1 bits wide.
  - When full, ack=0 for that cycle; a pop in the same cycle re-enables ack on the next cycle.
  - Words beyond len_q are never acked; they stay pending at the leaf interface for the next frame.
  - A pop with m_tlast moves the state to DONE.
  - A new start while in STREAM aborts the frame: flush FIFO, zero counters, relatch frame_len, stay in STREAM (or go to DONE if frame_len==0). done is not pulsed for the aborted frame.
- DONE:
  - done=1 for exactly one cycle, ack=0, m_tvalid=0; then go to IDLE.
  - A start in this cycle is honoured as in IDLE, and done still pulses.
- busy = (state == STREAM).
- All counter comparisons are unsigned; len_q-1 is computed in LEN_BITS.

Test Plan:
- Reset, then ap_start rise with frame_len=5, vld held high, m_tready held high, incrementing data 1..5:
  - ack high for exactly 5 pushes.
  - m_tdata 1..5, each 1 cycle after its push.
  - m_tlast only with word 5; done pulses 1 cycle after word 5 transfers; ack=0 afterwards with vld still high.
- frame_len=40, FIFO depth 16, m_tready=0 for 30 cycles, then 1:
  - ack drops after 16 pushes.
  - Flow resumes once draining starts; all 40 words arrive in order with no loss or duplication; tlast on word 40.
- Random vld and random m_tready, frame_len=100, 1000 seeds:
  - Output sequence equals input sequence.
  - Exactly one tlast and one done per frame.
  - fifo_count never exceeds 16.
- ap_start rise with frame_len=0: done pulses, ack never asserts, m_tvalid never asserts.
- Mid-frame abort:
  - frame_len=10, 4 words pushed, 2 popped; new ap_start rise with frame_len=3.
  - The 2 buffered words are discarded, no done for the first frame, the next 3 words stream with tlast on the 3rd, then done.
- reset asserted with 6 words buffered: next cycle m_tvalid=0, ack=0, busy=0; a subsequent start behaves as from a fresh reset.

Source files
------------

// File: rtl/leaf_stream_adapter.sv
// leaf_stream_adapter: one input port's vld/ack word stream -> FWFT FIFO -> AXI-Stream master with tlast from frame_len.
// Latency: a word acked at edge t is presented on m_tdata/m_tvalid right after edge t (1 cycle).
// Backpressure: m_tready stalls pops; ack drops when the FIFO is full or the frame's words have all been accepted.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   ap_start, frame_len              rising edge of ap_start starts a frame of frame_len words
//   din_leaf_interface2user, vld_interface2user, ack_user2interface   upstream word handshake
//   m_tdata, m_tvalid, m_tready, m_tlast                               downstream AXI-Stream master
//   done                             one-cycle pulse after the frame's last word transfers
//   busy                             high while streaming a frame
module leaf_stream_adapter #(
  parameter int PAYLOAD_BITS   = 32,
  parameter int FIFO_ADDR_BITS = 4,
  parameter int LEN_BITS       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ap_start,
  input  logic [LEN_BITS-1:0]     frame_len,
  input  logic [PAYLOAD_BITS-1:0] din_leaf_interface2user,
  input  logic                    vld_interface2user,
  output logic                    ack_user2interface,
  output logic [PAYLOAD_BITS-1:0] m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    done,
  output logic                    busy
);

  localparam int DEPTH = 1 << FIFO_ADDR_BITS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_ap_start_q;
  logic [LEN_BITS-1:0]       r_len_q;
  logic [LEN_BITS-1:0]       r_in_cnt;
  logic [LEN_BITS-1:0]       r_out_cnt;
  logic [FIFO_ADDR_BITS-1:0] r_wr_ptr;
  logic [FIFO_ADDR_BITS-1:0] r_rd_ptr;
  logic [FIFO_ADDR_BITS:0]   r_count;
  logic [PAYLOAD_BITS-1:0]   r_mem [DEPTH];

  logic                      w_start;
  logic                      w_stream;
  logic                      w_full;
  logic                      w_ack;
  logic                      w_tvalid;
  logic                      w_tlast;
  logic                      w_push;
  logic                      w_pop;
  logic [LEN_BITS-1:0]       w_len_m1;

  assign w_start  = ap_start & ~r_ap_start_q;
  assign w_stream = (r_state == S_STREAM);

  // Count never exceeds DEPTH, so its MSB alone marks a full FIFO.
  assign w_full   = r_count[FIFO_ADDR_BITS];

  // ack depends only on registered state, keeping m_tready out of the upstream path.
  assign w_ack    = w_stream & ~w_full & (r_in_cnt < r_len_q);
  assign w_tvalid = w_stream & (r_count != '0);
  assign w_len_m1 = r_len_q - LEN_BITS'(1);
  assign w_tlast  = w_tvalid & (r_out_cnt == w_len_m1);
  assign w_push   = vld_interface2user & w_ack;
  assign w_pop    = w_tvalid & m_tready;

  assign ack_user2interface = w_ack;
  assign m_tvalid           = w_tvalid;
  assign m_tlast            = w_tlast;
  // Head is gated so stale RAM contents never leak out while idle or after reset.
  assign m_tdata            = w_tvalid ? r_mem[r_rd_ptr] : '0;
  assign done               = (r_state == S_DONE);
  assign busy               = w_stream;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = (frame_len != '0) ? S_STREAM : S_DONE;
      end
      S_STREAM: begin
        // A restart aborts the current frame without reporting done for it.
        if (w_start)              w_state_nxt = (frame_len != '0) ? S_STREAM : S_DONE;
        else if (w_pop & w_tlast) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        if (w_start) w_state_nxt = (frame_len != '0) ? S_STREAM : S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ap_start_q <= 1'b0;
      r_len_q      <= '0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_ap_start_q <= ap_start;
      r_state      <= w_state_nxt;
      if (w_start) begin
        // Any start flushes buffered words; a push in this same cycle is dropped.
        r_len_q   <= frame_len;
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_count   <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + FIFO_ADDR_BITS'(1);
          r_in_cnt <= r_in_cnt + LEN_BITS'(1);
        end
        if (w_pop) begin
          r_rd_ptr  <= r_rd_ptr + FIFO_ADDR_BITS'(1);
          r_out_cnt <= r_out_cnt + LEN_BITS'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (FIFO_ADDR_BITS+1)'(1);
          2'b01:   r_count <= r_count - (FIFO_ADDR_BITS+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din_leaf_interface2user;
  end

endmodule
